multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle MIPS control decoder.
- Same opcode/funct map and aluop encoding, sequenced as an FSM over a shared instruction/data memory with a ready handshake.
- Adds a memory-wait timeout and sticky fault reporting.
- Sits between the IR/ALU datapath and the unified memory port of the multi-cycle core.

Parameters:
ALUOP_W, 4, aluop width; must be >=4; upper bits above [3:0] driven 0.
TIMEOUT, 16, max cycles spent in any single memory wait state before fault; range 2..255.

Ports:
clk  in  1  core clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  6  IR[31:26].
funct  in  6  IR[5:0].
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes current read/write this cycle.
ir_write  out  1  load IR from mem read data.
pc_write  out  1  update PC.
pc_src  out  2  0=ALU result (PC+4), 1=ALUOut (branch target), 2=jump target, 3=rs (JR).
iord  out  1  0=PC addresses memory, 1=ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
reg_write  out  1  register file write enable.
reg_dst  out  2  0=rt, 1=rd, 2=$31.
mem_to_reg  out  1  writeback from MDR.
jal  out  1  writeback data = PC (link).
alu_src_a  out  1  0=PC, 1=rs.
alu_src_b  out  2  0=rt, 1=4, 2=sign-ext imm, 3=shifted imm.
aluop  out  ALUOP_W  ADD 0, SUB 1, AND 2, OR 3, NOR 4, XOR 5, SLT 6, SLL 7, SRL 8, SGT 9.
fault  out  1  sticky illegal-instruction/timeout flag.
state  out  4  current state code, for debug.

Behaviour:
- States and codes:
  - INIT 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, ALU_WB 5.
  - MEM_ADDR 6, MEM_RD 7, MEM_WB 8, MEM_WR 9.
  - BRANCH 10, JUMP 11, FAULT 12.
- Outputs are Moore and decoded from the registered state.
  - Exceptions: pc_write in BRANCH, and the mem_ready-gated strobes noted below.
- Reset: state=INIT, fault=0, wait counter=0, latched op/funct=0. All outputs are 0 in INIT. INIT -> FETCH unconditionally.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, aluop=ADD.
  - ir_write and pc_write (pc_src=0) assert only in the cycle mem_ready=1; then -> DECODE.
  - Otherwise stays in FETCH.
- DECODE:
  - Latches opcode/funct; ALU computes branch target (alu_src_a=0, alu_src_b=3, ADD).
  - Dispatch:
    - R-type (0) -> EXEC_R.
    - ADDI 08, ANDI 0c, ORI 0d, XORI 0e, SLTI 0a -> EXEC_I.
    - LW 23, SW 2b -> MEM_ADDR.
    - BEQ 04, BNE 05 -> BRANCH.
    - J 02, JAL 03 -> JUMP.
    - Anything else -> FAULT.
- EXEC_R:
  - alu_src_a=1, alu_src_b=0; aluop from funct: 20 ADD, 22 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2a SLT, 2c SGT.
  - SLL 00 / SRL 02 use alu_src_b=2 with aluop SLL/SRL.
  - JR 08: pc_write=1, pc_src=3, -> FETCH with no writeback.
  - Other legal funct -> ALU_WB; unknown funct -> FAULT.
- EXEC_I: alu_src_a=1, alu_src_b=2; aluop per opcode (ADD/AND/OR/XOR/SLT); -> ALU_WB.
- ALU_WB: reg_write=1; reg_dst=1 if latched op is R-type else 0; mem_to_reg=0; -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD; -> MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1; -> MEM_WB on mem_ready.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
- MEM_WR: mem_write=1, iord=1; -> FETCH on mem_ready.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, SUB, pc_src=1.
  - pc_write = (BEQ & zero) | (BNE & ~zero).
  - -> FETCH.
- JUMP:
  - pc_write=1, pc_src=2.
  - JAL additionally drives reg_write=1, reg_dst=2, jal=1.
  - -> FETCH.
- Timeout:
  - Wait counter clears on entering FETCH/MEM_RD/MEM_WR and increments each cycle there while mem_ready=0.
  - Reaching TIMEOUT-1 with mem_ready=0 -> FAULT.
  - mem_ready=1 on that same cycle wins: normal transition, no fault.
- FAULT:
  - All strobes 0, fault=1; absorbing until rst_n low.
- Reset asserted mid-operation: state returns to INIT immediately (async); no strobe may remain high.
- mem_read and mem_write are never high in the same cycle.

Test Plan:
- ADD (op 00, funct 20), mem_ready=1 always -> states 1,2,3,5,1. ir_write/pc_write one cycle in FETCH; reg_write=1, reg_dst=1, aluop=0 in ALU_WB.
- LW (op 23), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1, iord=1; then MEM_WB with reg_write=1, mem_to_reg=1; fault=0.
- BEQ with zero=1 -> pc_write=1, pc_src=1 in BRANCH. BNE with zero=1 -> pc_write=0.
- JAL (op 03) -> JUMP with pc_write=1, pc_src=2, reg_dst=2, jal=1, reg_write=1. JR (funct 08) -> pc_src=3, reg_write never 1.
- Timeout: mem_ready=0 held in FETCH with TIMEOUT=16 -> fault=1 and state=12 after 16 FETCH cycles. Same case with mem_ready=1 on the 16th cycle -> DECODE, fault=0.
- Illegal opcode 3f -> FAULT, fault stays 1 for 20 cycles. rst_n pulse mid-MEM_WR -> outputs 0 immediately, state=0, then FETCH.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Multi-cycle MIPS control sequencer. Walks each instruction through
//   fetch/decode/execute/memory/writeback over a shared instruction/data
//   memory port with a ready handshake. A memory wait that runs too long,
//   or an illegal opcode/funct, parks the machine in FAULT until reset.
//
// Ports
//   clk, rst_n           core clock (rising edge), async active-low reset
//   opcode, funct        IR[31:26], IR[5:0]; sampled in DECODE
//   zero                 ALU zero flag, used by BEQ/BNE in BRANCH
//   mem_ready            memory finishes the current access this cycle
//   ir_write .. alu_src_b  datapath control strobes / mux selects
//   aluop                ALU operation, upper bits above [3:0] are zero
//   fault                sticky illegal-instruction / timeout flag
//   state                current state code (debug)
module multicycle_control_fsm #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic [1:0]         reg_dst,
  output logic               mem_to_reg,
  output logic               jal,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] aluop,
  output logic               fault,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_FAULT    = 4'd12
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_NOR = 4'd4, ALU_XOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
    ALU_SRL = 4'd8, ALU_SGT = 4'd9
  } alu_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic [7:0] wait_q, wait_d;
  logic       fault_q, fault_d;
  logic       in_wait;
  alu_e       alu_sel;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // Next state, wait counter and sticky fault.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          6'h00:                             state_d = S_EXEC_R;
          6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: state_d = S_EXEC_I;
          6'h23, 6'h2b:                      state_d = S_MEM_ADDR;
          6'h04, 6'h05:                      state_d = S_BRANCH;
          6'h02, 6'h03:                      state_d = S_JUMP;
          default:                           state_d = S_FAULT;
        endcase
      end
      S_EXEC_R: begin
        case (fn_q)
          FN_JR:                                           state_d = S_FETCH;
          6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2a, 6'h2c, 6'h00, 6'h02:                      state_d = S_ALU_WB;
          default:                                         state_d = S_FAULT;
        endcase
      end
      S_EXEC_I:   state_d = S_ALU_WB;
      S_ALU_WB:   state_d = S_FETCH;
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    // A ready on the last allowed wait cycle still completes normally.
    if (in_wait && !mem_ready && (wait_q == WAIT_LAST)) state_d = S_FAULT;

    // Counter runs only while parked in the same wait state; any move clears it.
    wait_d  = (in_wait && (state_d == state_q)) ? wait_q + 8'd1 : '0;
    fault_d = fault_q || (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      wait_q  <= '0;
      fault_q <= 1'b0;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  // Moore decode of the registered state; FETCH/BRANCH add input-gated strobes.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 1'b0;
    jal        = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_sel    = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'd3;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        case (fn_q)
          6'h20: alu_sel = ALU_ADD;
          6'h22: alu_sel = ALU_SUB;
          6'h24: alu_sel = ALU_AND;
          6'h25: alu_sel = ALU_OR;
          6'h26: alu_sel = ALU_XOR;
          6'h27: alu_sel = ALU_NOR;
          6'h2a: alu_sel = ALU_SLT;
          6'h2c: alu_sel = ALU_SGT;
          6'h00: begin alu_sel = ALU_SLL; alu_src_b = 2'd2; end
          6'h02: begin alu_sel = ALU_SRL; alu_src_b = 2'd2; end
          FN_JR: begin pc_write = 1'b1; pc_src = 2'd3; end
          default: alu_sel = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (op_q)
          6'h0c:   alu_sel = ALU_AND;
          6'h0d:   alu_sel = ALU_OR;
          6'h0e:   alu_sel = ALU_XOR;
          6'h0a:   alu_sel = ALU_SLT;
          default: alu_sel = ALU_ADD;
        endcase
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = ALU_SUB;
        pc_src    = 2'd1;
        pc_write  = ((op_q == OP_BEQ) && zero) || ((op_q == OP_BNE) && !zero);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'd2;
        if (op_q == OP_JAL) begin
          reg_write = 1'b1;
          reg_dst   = 2'd2;
          jal       = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign aluop = ALUOP_W'(alu_sel);
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: directed instruction sequences
// followed by random instructions, random memory latencies and random
// don't-care inputs, each checked cycle by cycle against an
// instruction-level reference model.
module tb_multicycle_control_fsm;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       ir_write, pc_write, iord, mem_read, mem_write, reg_write;
  logic       mem_to_reg, jal, alu_src_a, fault;
  logic [1:0] pc_src, reg_dst, alu_src_b;
  logic [3:0] aluop, state;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.ALUOP_W(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .jal(jal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
    .fault(fault), .state(state)
  );

  typedef struct packed {
    logic       ir_write, pc_write;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg, jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] aluop;
    logic       fault;
    logic [3:0] state;
  } obs_t;

  typedef enum {C_RALU, C_JR, C_RBAD, C_IALU, C_LW, C_SW, C_BR, C_J, C_BAD} icls_e;

  int n_checks = 0;
  int n_fail   = 0;
  int tail_len = 3;

  function automatic obs_t blank(input logic [3:0] st);
    obs_t e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ir_write = ir_write;   o.pc_write = pc_write;   o.pc_src = pc_src;
    o.iord = iord;           o.mem_read = mem_read;   o.mem_write = mem_write;
    o.reg_write = reg_write; o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;
    o.jal = jal;             o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b;
    o.aluop = aluop;         o.fault = fault;         o.state = state;
    return o;
  endfunction

  function automatic icls_e classify(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h08: return C_JR;
               6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2c, 6'h00, 6'h02: return C_RALU;
               default: return C_RBAD;
             endcase
      6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a: return C_IALU;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02, 6'h03: return C_J;
      default: return C_BAD;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h22: return 4'd1;  6'h24: return 4'd2;  6'h25: return 4'd3;
      6'h26: return 4'd5;  6'h27: return 4'd4;  6'h2a: return 4'd6;
      6'h2c: return 4'd9;  6'h00: return 4'd7;  6'h02: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h0c: return 4'd2;  6'h0d: return 4'd3;
      6'h0e: return 4'd5;  6'h0a: return 4'd6;
      default: return 4'd0;
    endcase
  endfunction

  function automatic obs_t e_fetch(input bit done);
    obs_t e = blank(4'd1);
    e.mem_read  = 1'b1;
    e.alu_src_b = 2'd1;
    e.ir_write  = done;
    e.pc_write  = done;
    return e;
  endfunction

  function automatic obs_t e_fault();
    obs_t e = blank(4'd12);
    e.fault = 1'b1;
    return e;
  endfunction

  task automatic check(input obs_t e, input string tag);
    obs_t o = sample();
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
    n_checks++;
    assert ((mem_read & mem_write) === 1'b0) else begin
      n_fail++;
      $error("FAIL %s_rw_excl observed=%b%b expected=not both high", tag, mem_read, mem_write);
    end
  endtask

  // Called at posedge+1 with inputs already driven; leaves at the next posedge+1.
  task automatic step(input obs_t e, input string tag);
    #1;
    check(e, tag);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check(blank(4'd0), "rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(blank(4'd0), "init");
  endtask

  task automatic fault_tail(input int k);
    for (int i = 0; i < k; i++) begin
      opcode = 6'($urandom); funct = 6'($urandom);
      zero = 1'($urandom);   mem_ready = 1'($urandom);
      step(e_fault(), "fault_hold");
    end
    do_reset();
  endtask

  // n cycles with mem_ready low, then one with it high; TO low cycles in a row is a timeout.
  task automatic wait_phase(input obs_t ew, input obs_t ed, input int n,
                            input string tag, output bit faulted);
    faulted = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'b0;
      step(ew, tag);
      if (i == TO - 1) begin
        faulted = 1'b1;
        return;
      end
    end
    mem_ready = 1'b1;
    step(ed, tag);
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int mw);
    obs_t  e;
    bit    faulted;
    icls_e c = classify(op, fn);
    opcode = op; funct = fn; zero = 1'($urandom);
    wait_phase(e_fetch(1'b0), e_fetch(1'b1), fw, "fetch", faulted);
    if (faulted) begin fault_tail(tail_len); return; end
    mem_ready = 1'($urandom);
    e = blank(4'd2); e.alu_src_b = 2'd3;
    step(e, "decode");
    // IR may change after DECODE; later states must use the latched copy.
    opcode = 6'($urandom); funct = 6'($urandom); mem_ready = 1'($urandom);
    case (c)
      C_RALU: begin
        e = blank(4'd3); e.alu_src_a = 1'b1; e.aluop = r_alu(fn);
        e.alu_src_b = (fn == 6'h00 || fn == 6'h02) ? 2'd2 : 2'd0;
        step(e, "exec_r");
        e = blank(4'd5); e.reg_write = 1'b1; e.reg_dst = 2'd1;
        step(e, "alu_wb_r");
      end
      C_JR: begin
        e = blank(4'd3); e.alu_src_a = 1'b1; e.pc_write = 1'b1; e.pc_src = 2'd3;
        step(e, "exec_jr");
      end
      C_RBAD: begin
        e = blank(4'd3); e.alu_src_a = 1'b1;
        step(e, "exec_rbad");
        fault_tail(tail_len);
      end
      C_IALU: begin
        e = blank(4'd4); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2; e.aluop = i_alu(op);
        step(e, "exec_i");
        e = blank(4'd5); e.reg_write = 1'b1;
        step(e, "alu_wb_i");
      end
      C_LW, C_SW: begin
        e = blank(4'd6); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        step(e, "mem_addr");
        e = blank((c == C_LW) ? 4'd7 : 4'd9); e.iord = 1'b1;
        if (c == C_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        wait_phase(e, e, mw, (c == C_LW) ? "mem_rd" : "mem_wr", faulted);
        if (faulted) fault_tail(tail_len);
        else if (c == C_LW) begin
          mem_ready = 1'($urandom);
          e = blank(4'd8); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          step(e, "mem_wb");
        end
      end
      C_BR: begin
        zero = z;
        e = blank(4'd10); e.alu_src_a = 1'b1; e.aluop = 4'd1; e.pc_src = 2'd1;
        e.pc_write = (op == 6'h04) ? z : !z;
        step(e, "branch");
      end
      C_J: begin
        e = blank(4'd11); e.pc_write = 1'b1; e.pc_src = 2'd2;
        if (op == 6'h03) begin e.reg_write = 1'b1; e.reg_dst = 2'd2; e.jal = 1'b1; end
        step(e, "jump");
      end
      default: fault_tail(tail_len);
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops [17] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0e, 6'h0a, 6'h23,
                             6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f, 6'h01, 6'h10};
    logic [5:0] fns [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2c,
                             6'h00, 6'h02, 6'h08, 6'h01, 6'h3f};
    obs_t e;
    bit   faulted;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(6'h00, 6'h20, 1'b0, 0, 0);   // ADD
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);   // LW, 3 wait cycles
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);   // BEQ taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);   // BNE not taken
    run_instr(6'h04, 6'h00, 1'b0, 1, 0);
    run_instr(6'h05, 6'h00, 1'b0, 2, 0);
    run_instr(6'h03, 6'h00, 1'b0, 0, 0);   // JAL
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);   // JR
    run_instr(6'h00, 6'h20, 1'b0, 16, 0);  // fetch timeout
    run_instr(6'h00, 6'h20, 1'b0, 15, 0);  // ready on the last allowed cycle
    run_instr(6'h23, 6'h00, 1'b0, 0, 16);  // MEM_RD timeout
    run_instr(6'h2b, 6'h00, 1'b0, 0, 15);  // MEM_WR completes at the limit
    tail_len = 20;
    run_instr(6'h3f, 6'h00, 1'b0, 0, 0);   // illegal opcode
    tail_len = 3;

    // Reset pulse while MEM_WR is waiting on memory.
    opcode = 6'h2b; funct = '0;
    wait_phase(e_fetch(1'b0), e_fetch(1'b1), 0, "fetch", faulted);
    e = blank(4'd2); e.alu_src_b = 2'd3;
    step(e, "decode");
    e = blank(4'd6); e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    step(e, "mem_addr");
    mem_ready = 1'b0;
    e = blank(4'd9); e.mem_write = 1'b1; e.iord = 1'b1;
    step(e, "mem_wr");
    do_reset();
    mem_ready = 1'b1;
    step(e_fetch(1'b1), "fetch_after_rst");
    do_reset();

    for (int n = 0; n < 120; n++) begin
      int fw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 3));
      int mw = ($urandom_range(0, 7) == 0)  ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 4));
      run_instr(ops[$urandom_range(0, 16)], fns[$urandom_range(0, 12)],
                1'($urandom), fw, mw);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
